// File: rtl/rv32_types_pkg.sv
// Shared types for the RV32 pipeline controller: stage indices, controller
// FSM states and the per-stage stop/flush payload.
package rv32_types;

  localparam int unsigned PIPE_STAGES  = 5;
  localparam int unsigned STAGE_FETCH  = 0;
  localparam int unsigned STAGE_DECODE = 1;
  localparam int unsigned STAGE_EXEC   = 2;
  localparam int unsigned STAGE_MEM    = 3;
  localparam int unsigned STAGE_WB     = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_TAKE   = 2'd2,
    ST_RESUME = 2'd3
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic [PIPE_STAGES-1:0] stop;
    logic [PIPE_STAGES-1:0] flush;
  } pipe_ctrl_t;

endpackage

// File: rtl/rv32_sat_counter.sv
// Saturating up-counter with synchronous active-low reset; sticks at all ones.
module rv32_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/rv32_pipeline_controller.sv
// Stall/flush sequencer for the 5-stage RV32 core with interrupt-entry drain FSM.
// Optional performance counters are built when RV32_PIPECTRL_PERF_EN is defined.
module rv32_pipeline_controller
  import rv32_types::*;
#(
  parameter int unsigned NUM_STAGES = PIPE_STAGES,
  parameter int unsigned DRAIN_MAX  = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  decode_stall,
  input  logic                  mem_busy,
  input  logic                  jump_do,
  input  logic                  irq_pending,
  input  logic [NUM_STAGES-1:0] stage_valid,
  output logic [NUM_STAGES-1:0] stop,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  irq_take,
  output logic [1:0]            ctrl_state,
  output logic [CNT_W-1:0]      perf_hazard_cnt,
  output logic [CNT_W-1:0]      perf_mem_cnt,
  output logic [CNT_W-1:0]      perf_irq_cnt
);

  localparam int unsigned       DCNT_W     = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_MAX - 1);

  pipe_ctrl_state_t  state, state_nxt;
  logic [DCNT_W-1:0] dcnt, dcnt_nxt;
  pipe_ctrl_t        ctrl;
  logic              take;
  logic              exec_mem_empty;
  logic              unused_valid;

  assign exec_mem_empty = ~|stage_valid[STAGE_MEM:STAGE_EXEC];
  assign unused_valid   = ^{stage_valid[STAGE_DECODE:STAGE_FETCH],
                            stage_valid[NUM_STAGES-1:STAGE_WB]};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_RUN;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  // Next state and combinational stop/flush/irq_take; mem_busy freezes everything.
  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    ctrl      = '0;
    take      = 1'b0;
    if (mem_busy) begin
      ctrl.stop = '1;
    end else begin
      case (state)
        ST_RUN: begin
          if (jump_do) begin
            ctrl.flush[STAGE_FETCH] = 1'b1;
          end else if (decode_stall) begin
            ctrl.stop[STAGE_FETCH]  = 1'b1;
            ctrl.stop[STAGE_DECODE] = 1'b1;
          end
          if (irq_pending && !jump_do) begin
            state_nxt = ST_DRAIN;
            dcnt_nxt  = '0;
          end
        end
        ST_DRAIN: begin
          ctrl.stop[STAGE_FETCH]   = 1'b1;
          ctrl.flush[STAGE_DECODE] = 1'b1;
          if (jump_do) ctrl.flush[STAGE_FETCH] = 1'b1;
          if (dcnt != DRAIN_LAST) dcnt_nxt = dcnt + DCNT_W'(1);
          if (!irq_pending) begin
            state_nxt = ST_RESUME;
          end else if (exec_mem_empty || (dcnt == DRAIN_LAST)) begin
            state_nxt = ST_TAKE;
          end
        end
        ST_TAKE: begin
          take                     = 1'b1;
          ctrl.flush[STAGE_FETCH]  = 1'b1;
          ctrl.flush[STAGE_DECODE] = 1'b1;
          state_nxt                = ST_RUN;
        end
        ST_RESUME: begin
          ctrl.flush[STAGE_FETCH] = 1'b1;
          state_nxt               = ST_RUN;
        end
        default: state_nxt = ST_RUN;
      endcase
    end
    ctrl.stop = ctrl.stop & ~ctrl.flush;
    // A reset cycle must never leak a take or stale stop/flush from the old state.
    if (!resetn) begin
      ctrl = '0;
      take = 1'b0;
    end
  end

  assign stop       = NUM_STAGES'(ctrl.stop);
  assign flush      = NUM_STAGES'(ctrl.flush);
  assign irq_take   = take;
  assign ctrl_state = 2'(state);

`ifdef RV32_PIPECTRL_PERF_EN
  logic hazard_inc;
  assign hazard_inc = (state == ST_RUN) && decode_stall && !mem_busy;

  rv32_sat_counter #(.WIDTH(CNT_W)) u_hazard_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (hazard_inc),
    .count  (perf_hazard_cnt)
  );

  rv32_sat_counter #(.WIDTH(CNT_W)) u_mem_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (mem_busy),
    .count  (perf_mem_cnt)
  );

  rv32_sat_counter #(.WIDTH(CNT_W)) u_irq_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (take),
    .count  (perf_irq_cnt)
  );
`else
  assign perf_hazard_cnt = '0;
  assign perf_mem_cnt    = '0;
  assign perf_irq_cnt    = '0;
`endif

endmodule

// File: tb/tb_rv32_pipeline_controller.sv
// Self-checking bench for rv32_pipeline_controller: directed scenarios followed
// by random traffic, all compared against a behavioural model of the sequencer.
module tb_rv32_pipeline_controller;

  localparam int unsigned NS        = 5;
  localparam int unsigned DRAIN_MAX = 4;
  localparam int unsigned CW        = 32;

  logic          clk = 1'b0;
  logic          resetn, decode_stall, mem_busy, jump_do, irq_pending;
  logic [NS-1:0] stage_valid;
  logic [NS-1:0] stop, flush;
  logic          irq_take;
  logic [1:0]    ctrl_state;
  logic [CW-1:0] perf_hazard_cnt, perf_mem_cnt, perf_irq_cnt;

  rv32_pipeline_controller #(
    .NUM_STAGES (NS),
    .DRAIN_MAX  (DRAIN_MAX),
    .CNT_W      (CW)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .decode_stall    (decode_stall),
    .mem_busy        (mem_busy),
    .jump_do         (jump_do),
    .irq_pending     (irq_pending),
    .stage_valid     (stage_valid),
    .stop            (stop),
    .flush           (flush),
    .irq_take        (irq_take),
    .ctrl_state      (ctrl_state),
    .perf_hazard_cnt (perf_hazard_cnt),
    .perf_mem_cnt    (perf_mem_cnt),
    .perf_irq_cnt    (perf_irq_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model: phase 0=running, 1=draining, 2=taking, 3=resuming.
  int     m_phase  = 0;
  int     m_waited = 0;
  longint m_haz = 0, m_mem = 0, m_irq = 0;

  logic [NS-1:0] s_stop, s_flush;
  logic          s_take, s_prev_take;
  logic [1:0]    s_state;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic void expect_outputs(output logic [NS-1:0] es, output logic [NS-1:0] ef,
                                         output logic et);
    es = '0;
    ef = '0;
    et = 1'b0;
    if (!resetn) return;
    if (mem_busy) begin
      es = '1;
      return;
    end
    case (m_phase)
      0: begin
        if (jump_do) ef = 5'b00001;
        else if (decode_stall) es = 5'b00011;
      end
      1: begin
        es = jump_do ? 5'b00000 : 5'b00001;
        ef = jump_do ? 5'b00011 : 5'b00010;
      end
      2: begin
        et = 1'b1;
        ef = 5'b00011;
      end
      default: ef = 5'b00001;
    endcase
  endfunction

  task automatic model_advance(input logic et);
    if (!resetn) begin
      m_phase = 0; m_waited = 0; m_haz = 0; m_mem = 0; m_irq = 0;
    end else if (mem_busy) begin
      m_mem++;
    end else begin
      case (m_phase)
        0: begin
          if (decode_stall) m_haz++;
          if (irq_pending && !jump_do) begin
            m_phase  = 1;
            m_waited = 0;
          end
        end
        1: begin
          if (!irq_pending) m_phase = 3;
          else if (stage_valid[3:2] == 2'b00 || m_waited == DRAIN_MAX - 1) m_phase = 2;
          m_waited++;
        end
        2: begin
          if (et) m_irq++;
          m_phase = 0;
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  // One clock: drive inputs, compare against the model, then clock both.
  task automatic cyc(input logic rn, input logic ds, input logic mb, input logic jd,
                     input logic ip, input logic [NS-1:0] sv);
    logic [NS-1:0] es, ef;
    logic          et;
    resetn = rn; decode_stall = ds; mem_busy = mb; jump_do = jd; irq_pending = ip;
    stage_valid = sv;
    #1;
    expect_outputs(es, ef, et);
    s_stop = stop; s_flush = flush; s_take = irq_take; s_state = ctrl_state;
    check("stop", 64'(stop), 64'(es));
    check("flush", 64'(flush), 64'(ef));
    check("irq_take", 64'(irq_take), 64'(et));
    check("ctrl_state", 64'(ctrl_state), 64'(m_phase));
    check("stop_flush_overlap", 64'(stop & flush), 64'(0));
    check("take_back_to_back", 64'(irq_take & s_prev_take), 64'(0));
`ifdef RV32_PIPECTRL_PERF_EN
    check("perf_hazard", 64'(perf_hazard_cnt), 64'(m_haz));
    check("perf_mem", 64'(perf_mem_cnt), 64'(m_mem));
    check("perf_irq", 64'(perf_irq_cnt), 64'(m_irq));
`else
    check("perf_off", 64'({perf_hazard_cnt, perf_mem_cnt, perf_irq_cnt}), 64'(0));
`endif
    s_prev_take = irq_take;
    @(posedge clk);
    model_advance(et);
    #1;
  endtask

  initial begin
    logic ip;
    s_prev_take = 1'b0;
    resetn = 1'b0; decode_stall = 1'b0; mem_busy = 1'b0; jump_do = 1'b0;
    irq_pending = 1'b0; stage_valid = '0;
    @(posedge clk);
    #1;

    // Reset with idle inputs
    cyc(0, 0, 0, 0, 0, 5'b00000);
    cyc(0, 0, 0, 0, 0, 5'b00000);
    check("reset_state", 64'(ctrl_state), 64'(0));

    // Decode hazard for three cycles
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 0, 0, 5'b00000);
      check("hazard_stop", 64'(s_stop), 64'(5'b00011));
    end
`ifdef RV32_PIPECTRL_PERF_EN
    check("hazard_count3", 64'(perf_hazard_cnt), 64'(3));
`endif

    // Jump beats hazard
    cyc(1, 1, 0, 1, 0, 5'b00000);
    check("jump_flush", 64'(s_flush), 64'(5'b00001));
    check("jump_stop", 64'(s_stop), 64'(0));

    // Interrupt drain, exec/mem empties after two cycles
    cyc(1, 0, 0, 0, 1, 5'b01100);
    cyc(1, 0, 0, 0, 1, 5'b01100);
    check("drain_state", 64'(s_state), 64'(1));
    cyc(1, 0, 0, 0, 1, 5'b00000);
    cyc(1, 0, 0, 0, 0, 5'b00000);
    check("drain_take", 64'(s_take), 64'(1));
    cyc(1, 0, 0, 0, 0, 5'b00000);
    check("after_take", 64'({s_take, s_state}), 64'(0));

    // Forced take after DRAIN_MAX cycles with exec held valid
    cyc(1, 0, 0, 0, 1, 5'b00100);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0, 1, 5'b00100);
      check("forced_wait", 64'({s_take, s_state}), 64'(1));
    end
    cyc(1, 0, 0, 0, 0, 5'b00100);
    check("forced_take", 64'(s_take), 64'(1));

    // Freeze mid-drain: counter must hold across the freeze
    cyc(1, 0, 0, 0, 1, 5'b00100);
    cyc(1, 0, 0, 0, 1, 5'b00100);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 1, 1, 1, 5'b00100);
      check("freeze_stop", 64'(s_stop), 64'(5'b11111));
      check("freeze_state", 64'(s_state), 64'(1));
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 1, 5'b00100);
      check("post_freeze_drain", 64'(s_state), 64'(1));
    end
    cyc(1, 0, 0, 0, 0, 5'b00100);
    check("post_freeze_take", 64'(s_take), 64'(1));

    // Interrupt withdrawn during drain
    cyc(1, 0, 0, 0, 1, 5'b01000);
    cyc(1, 0, 0, 0, 0, 5'b01000);
    cyc(1, 0, 0, 0, 0, 5'b01000);
    check("resume_state", 64'(s_state), 64'(3));
    check("resume_flush", 64'(s_flush), 64'(5'b00001));
    check("resume_no_take", 64'(s_take), 64'(0));

    // Reset mid-drain and mid-take
    cyc(1, 0, 0, 0, 1, 5'b01000);
    cyc(0, 0, 0, 0, 1, 5'b01000);
    check("reset_drain_take", 64'(s_take), 64'(0));
    cyc(1, 0, 0, 0, 1, 5'b00000);
    cyc(1, 0, 0, 0, 1, 5'b00000);
    cyc(0, 0, 0, 0, 0, 5'b00000);
    check("reset_take_take", 64'(s_take), 64'(0));
    cyc(1, 0, 0, 0, 0, 5'b00000);
    check("reset_take_state", 64'(s_state), 64'(0));

    // Random traffic
    ip = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(9) == 0) ip = ~ip;
      cyc(($urandom_range(63) != 0), ($urandom_range(3) == 0), ($urandom_range(5) == 0),
          ($urandom_range(5) == 0), ip, NS'($urandom));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rv32_pipeline_controller.md
Name: rv32_pipeline_controller

Overview:
Central stall/flush sequencer for the 5-stage RV32 core: fetch=0, decode=1, exec=2, mem=3, wb=4.
- Merges the decode hazard stall, the data-memory busy signal and taken jumps into per-stage stop/flush vectors.
- Runs an interrupt-entry FSM that drains in-flight instructions before pulsing the interrupt request the decode stage consumes.

Parameters:
NUM_STAGES, 5, number of pipeline stages; bit i of every vector refers to stage i.
DRAIN_MAX, 4, upper bound on drain cycles before the interrupt is forced; minimum value 1.
CNT_W, 32, width of the optional performance counters.

Ports:
clk  in  1  clock; all logic on posedge.
resetn  in  1  reset; synchronous, active-low.
decode_stall  in  1  hazard stall raised by the decode stage.
mem_busy  in  1  data memory not ready; global freeze request.
jump_do  in  1  taken jump/branch resolved this cycle.
irq_pending  in  1  level interrupt line, already masked by MIE.
stage_valid  in  NUM_STAGES  stage i holds a non-bubble instruction.
stop  out  NUM_STAGES  hold stage i's output buffer.
flush  out  NUM_STAGES  load a bubble into stage i's output buffer.
irq_take  out  1  one-cycle pulse driving the interrupt request's do_interrupt.
ctrl_state  out  2  current FSM state, for debug.
perf_hazard_cnt  out  CNT_W  decode-stall cycles; optional, 0 when the feature is compiled out.
perf_mem_cnt  out  CNT_W  mem_busy cycles; optional, 0 when the feature is compiled out.
perf_irq_cnt  out  CNT_W  interrupts taken; optional, 0 when the feature is compiled out.

Behaviour:
Reset (resetn=0 at posedge):
- State = RUN, drain counter = 0, perf counters = 0.
- stop, flush and irq_take are combinational and evaluate to 0 in RUN while no request is present.

States: RUN=0, DRAIN=1, TAKE=2, RESUME=3.

Priority 1, mem_busy=1 in any state:
- stop = all ones; flush = 0; irq_take = 0.
- FSM state and drain counter hold.
- jump_do and decode_stall are ignored that cycle; their sources keep them asserted.

RUN:
- decode_stall=1: stop[0]=stop[1]=1. Decode inserts the bubble itself, so flush stays 0.
- jump_do=1: flush[0]=1. Jump wins over decode_stall, so stop[1:0]=0.
- irq_pending=1 with jump_do=0: go to DRAIN next cycle and clear the counter.
- irq_pending=1 with jump_do=1: stay in RUN; the interrupt is re-evaluated the following cycle.

DRAIN:
- Outputs: stop[0]=1 and flush[1]=1, so no new instruction enters exec.
- Counter increments each non-frozen cycle.
- Go to TAKE when stage_valid[3:2]==0 or counter==DRAIN_MAX-1.
- jump_do during DRAIN: flush[0]=1; stay in DRAIN.
- irq_pending drops during DRAIN: go to RESUME, no take.

TAKE:
- Exactly one cycle: irq_take=1, flush[1:0]=2'b11.
- Next state RUN, unless mem_busy holds the state.

RESUME:
- One cycle: stop=0, flush[0]=1 so fetch refetches from the preserved PC.
- Next state RUN.

General rules:
- irq_take is asserted only in TAKE and never on two consecutive cycles.
- stop and flush are never both 1 for the same stage; flush wins.
- A synchronous reset mid-DRAIN or mid-TAKE returns to RUN with no irq_take.

Optional Feature:
RV32_PIPECTRL_PERF_EN:
- Defined: three saturating CNT_W-bit counters.
  - perf_hazard_cnt increments on RUN with decode_stall=1 and mem_busy=0.
  - perf_mem_cnt increments on mem_busy=1.
  - perf_irq_cnt increments on irq_take=1.
  - Each counter stops at all ones.
- Undefined: no counter registers are instantiated; the three perf ports are tied to 0.

Decomposition:
Shared package rv32_types:
- pipe_ctrl_state_t enum (RUN/DRAIN/TAKE/RESUME).
- Stage index constants STAGE_FETCH..STAGE_WB.
- pipe_ctrl_t struct {stop, flush}.

Sub-module rv32_sat_counter:
- Width param; ports clk, resetn, inc, count.
- Instantiated three times, only under RV32_PIPECTRL_PERF_EN.

Test Plan:
- Reset: hold resetn=0 for 2 cycles with all inputs 0 -> stop=0, flush=0, irq_take=0, ctrl_state=0.
- Hazard: decode_stall=1 for 3 cycles -> stop=5'b00011 each cycle; with PERF_EN, perf_hazard_cnt=3.
- Jump plus hazard same cycle: jump_do=1, decode_stall=1 -> flush=5'b00001, stop=0.
- Interrupt drain: irq_pending=1, stage_valid=5'b01100 clearing after 2 cycles -> DRAIN for 2 cycles, TAKE on cycle 3 with irq_take=1 for one cycle, then RUN.
- Forced take: stage_valid[2]=1 held, DRAIN_MAX=4 -> irq_take exactly 4 cycles after DRAIN entry.
- Freeze during DRAIN: mem_busy=1 for 5 cycles mid-drain -> stop=5'b11111, state held, counter unchanged; drain resumes when mem_busy drops. irq_pending dropped in DRAIN -> RESUME, flush[0]=1, no irq_take.
